clusterv_sram_arbiter: RTL and testbench



---
 rtl/clusterv_sram_arb_pkg.sv | 15 +
 rtl/clusterv_rr_arb2.sv | 41 ++++
 rtl/clusterv_sram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_clusterv_sram_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clusterv_sram_arb_pkg.sv
// Shared definitions for the tile SRAM arbiter.
// Contents: FSM state encoding and port-index constants.
package clusterv_sram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmd  = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    // Port indices: core-side interconnect path and host/DMA initiator.
    localparam logic PortCore = 1'b0;
    localparam logic PortHost = 1'b1;

endpackage

// File: rtl/clusterv_rr_arb2.sv
// Two-requester round-robin arbiter.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   req[1:0]       : request per port
//   grant_en       : arbitration allowed this cycle
//   gnt[1:0]       : one-hot grant (zero when disabled or no request)
// The last_grant register resets to the host port so the core port wins the first tie.
module clusterv_rr_arb2
    import clusterv_sram_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt
);

    logic last_grant_q;

    always_comb begin
        gnt = 2'b00;
        if (grant_en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // On a tie the port that did not win last time goes first.
                2'b11:   gnt = (last_grant_q == PortCore) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= PortHost;
        end else if (|gnt) begin
            last_grant_q <= gnt[1];
        end
    end

endmodule

// File: rtl/clusterv_sram_arbiter.sv
// Shares one single-port SRAM macro between two Wishbone classic initiators.
// Ports:
//   clock, reset_n            : clock and asynchronous active-low reset
//   pN_adr/dat_w/sel/we       : initiator N command (byte address, data, byte enables)
//   pN_cyc/stb                : initiator N Wishbone cycle and strobe
//   pN_ack/dat_r              : initiator N acknowledge and read data (zero unless acked)
//   sram_csb/web/wmask/addr   : registered macro command (csb, web active-low)
//   sram_dat_w / sram_dat_r   : macro write data / read data
// Each access runs IDLE -> CMD (csb low) -> RESP (ack), so ack follows the request
// edge by two cycles and the macro sees at most one access every three cycles.
module clusterv_sram_arbiter
    import clusterv_sram_arb_pkg::*;
#(
    parameter int unsigned SRAM_ADR_WIDTH = 8,
    parameter int unsigned DAT_WIDTH      = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [31:0]               p0_adr,
    input  logic [DAT_WIDTH-1:0]      p0_dat_w,
    output logic [DAT_WIDTH-1:0]      p0_dat_r,
    input  logic                      p0_cyc,
    input  logic                      p0_stb,
    input  logic                      p0_we,
    input  logic [DAT_WIDTH/8-1:0]    p0_sel,
    output logic                      p0_ack,
    input  logic [31:0]               p1_adr,
    input  logic [DAT_WIDTH-1:0]      p1_dat_w,
    output logic [DAT_WIDTH-1:0]      p1_dat_r,
    input  logic                      p1_cyc,
    input  logic                      p1_stb,
    input  logic                      p1_we,
    input  logic [DAT_WIDTH/8-1:0]    p1_sel,
    output logic                      p1_ack,
    output logic                      sram_csb,
    output logic                      sram_web,
    output logic [DAT_WIDTH/8-1:0]    sram_wmask,
    output logic [SRAM_ADR_WIDTH-1:0] sram_addr,
    output logic [DAT_WIDTH-1:0]      sram_dat_w,
    input  logic [DAT_WIDTH-1:0]      sram_dat_r
);

    arb_state_e state_q, state_d;

    logic [1:0]                req;
    logic [1:0]                gnt;
    logic                      grant_en;

    logic                      win_port;
    logic                      win_we;
    logic [31:0]               win_adr;
    logic [DAT_WIDTH-1:0]      win_dat_w;
    logic [DAT_WIDTH/8-1:0]    win_sel;

    logic                      gnt_port_q;
    logic                      we_q;
    logic                      abandon_q;
    logic                      gnt_cyc;
    logic                      resp_ack;

    logic                      csb_q;
    logic                      web_q;
    logic [DAT_WIDTH/8-1:0]    wmask_q;
    logic [SRAM_ADR_WIDTH-1:0] addr_q;
    logic [DAT_WIDTH-1:0]      dat_w_q;

    // Bits outside the word index are intentionally ignored; decode lives upstream.
    logic unused_adr;
    assign unused_adr = ^{p0_adr[31:SRAM_ADR_WIDTH+2], p0_adr[1:0],
                          p1_adr[31:SRAM_ADR_WIDTH+2], p1_adr[1:0]};

    assign req      = {p1_cyc & p1_stb, p0_cyc & p0_stb};
    assign grant_en = (state_q == StIdle);

    clusterv_rr_arb2 u_rr_arb2 (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .grant_en (grant_en),
        .gnt      (gnt)
    );

    always_comb begin
        win_port  = gnt[PortHost];
        win_we    = win_port ? p1_we    : p0_we;
        win_adr   = win_port ? p1_adr   : p0_adr;
        win_dat_w = win_port ? p1_dat_w : p0_dat_w;
        win_sel   = win_port ? p1_sel   : p0_sel;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (|gnt) state_d = StCmd;
            StCmd:   state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Command is latched at grant so the macro sees it for exactly the CMD cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt_port_q <= PortCore;
            we_q       <= 1'b0;
            abandon_q  <= 1'b0;
            csb_q      <= 1'b1;
            web_q      <= 1'b1;
            wmask_q    <= '0;
            addr_q     <= '0;
            dat_w_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|gnt) begin
                        gnt_port_q <= win_port;
                        we_q       <= win_we;
                        abandon_q  <= 1'b0;
                        csb_q      <= 1'b0;
                        web_q      <= ~win_we;
                        wmask_q    <= win_we ? win_sel : '0;
                        addr_q     <= win_adr[SRAM_ADR_WIDTH+1:2];
                        dat_w_q    <= win_dat_w;
                    end
                end
                StCmd: begin
                    csb_q <= 1'b1;
                    web_q <= 1'b1;
                    // Initiator gave up: the macro access completes but is not acked.
                    if (!gnt_cyc) abandon_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign sram_csb   = csb_q;
    assign sram_web   = web_q;
    assign sram_wmask = wmask_q;
    assign sram_addr  = addr_q;
    assign sram_dat_w = dat_w_q;

    assign gnt_cyc  = gnt_port_q ? p1_cyc : p0_cyc;
    assign resp_ack = (state_q == StResp) && !abandon_q && gnt_cyc;

    always_comb begin
        p0_ack   = 1'b0;
        p1_ack   = 1'b0;
        p0_dat_r = '0;
        p1_dat_r = '0;
        if (resp_ack) begin
            if (gnt_port_q == PortHost) begin
                p1_ack = 1'b1;
                if (!we_q) p1_dat_r = sram_dat_r;
            end else begin
                p0_ack = 1'b1;
                if (!we_q) p0_dat_r = sram_dat_r;
            end
        end
    end

endmodule

// File: tb/tb_clusterv_sram_arbiter.sv
module tb_clusterv_sram_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] p0_adr, p1_adr;
    logic [31:0] p0_dat_w, p1_dat_w, p0_dat_r, p1_dat_r;
    logic        p0_cyc, p0_stb, p0_we, p1_cyc, p1_stb, p1_we;
    logic [3:0]  p0_sel, p1_sel;
    logic        p0_ack, p1_ack;
    logic        sram_csb, sram_web;
    logic [3:0]  sram_wmask;
    logic [7:0]  sram_addr;
    logic [31:0] sram_dat_w;
    logic [31:0] sram_dat_r = 32'h0;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [256];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    clusterv_sram_arbiter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .p0_adr     (p0_adr),
        .p0_dat_w   (p0_dat_w),
        .p0_dat_r   (p0_dat_r),
        .p0_cyc     (p0_cyc),
        .p0_stb     (p0_stb),
        .p0_we      (p0_we),
        .p0_sel     (p0_sel),
        .p0_ack     (p0_ack),
        .p1_adr     (p1_adr),
        .p1_dat_w   (p1_dat_w),
        .p1_dat_r   (p1_dat_r),
        .p1_cyc     (p1_cyc),
        .p1_stb     (p1_stb),
        .p1_we      (p1_we),
        .p1_sel     (p1_sel),
        .p1_ack     (p1_ack),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_dat_w (sram_dat_w),
        .sram_dat_r (sram_dat_r)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Single-port macro model: one-cycle synchronous read, byte-masked write.
    always @(posedge clock) begin
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask[b]) mem[sram_addr][8*b +: 8] = sram_dat_w[8*b +: 8];
            end else begin
                sram_dat_r <= mem[sram_addr];
            end
        end
    end

    task automatic drive(input int port, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat);
        if (port == 0) begin
            p0_cyc = 1'b1; p0_stb = 1'b1; p0_we = we; p0_adr = adr; p0_sel = sel; p0_dat_w = dat;
        end else begin
            p1_cyc = 1'b1; p1_stb = 1'b1; p1_we = we; p1_adr = adr; p1_sel = sel; p1_dat_w = dat;
        end
    endtask

    task automatic idle_port(input int port);
        if (port == 0) begin
            p0_cyc = 1'b0; p0_stb = 1'b0; p0_we = 1'b0;
        end else begin
            p1_cyc = 1'b0; p1_stb = 1'b0; p1_we = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({sram_csb, sram_web} !== 2'b11) $display("FAIL reset_csb_web: got %b need 11", {sram_csb, sram_web});
        else n_pass++;
        n_checks++;
        if (sram_wmask !== 4'h0 || sram_addr !== 8'h0 || sram_dat_w !== 32'h0)
            $display("FAIL reset_cmd: got wmask=%h addr=%h dat_w=%h need all 0", sram_wmask, sram_addr, sram_dat_w);
        else n_pass++;
        n_checks++;
        if ({p0_ack, p1_ack} !== 2'b00 || p0_dat_r !== 32'h0 || p1_dat_r !== 32'h0)
            $display("FAIL reset_resp: got acks=%b dat_r=%h/%h need 0", {p0_ack, p1_ack}, p0_dat_r, p1_dat_r);
        else n_pass++;
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic_write();
        exp_t e;
        int   k;
        drive(0, 1'b1, 32'h2000_0010, 4'hF, 32'hDEAD_BEEF);
        k = cyc;
        exp_q.push_back('{port: 0, data: 32'h0, cyc: k + 2});
        @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_addr !== 8'd4 || sram_wmask !== 4'hF ||
            sram_dat_w !== 32'hDEAD_BEEF || p0_ack !== 1'b0)
            $display("FAIL wr_cmd: got csb=%b web=%b addr=%h wmask=%h dat=%h ack=%b need 0 0 04 f deadbeef 0",
                     sram_csb, sram_web, sram_addr, sram_wmask, sram_dat_w, p0_ack);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL wr_ack: scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_dat_r !== e.data || cyc != e.cyc)
                $display("FAIL wr_ack: got ack=%b/%b dat=%h cyc=%0d need 1/0 %h %0d",
                         p0_ack, p1_ack, p0_dat_r, cyc, e.data, e.cyc);
            else n_pass++;
        end
        n_checks++;
        if (sram_csb !== 1'b1 || sram_web !== 1'b1)
            $display("FAIL wr_cmd_len: got csb=%b web=%b in RESP need 1 1", sram_csb, sram_web);
        else n_pass++;
        @(posedge clock); #1;
        idle_port(0);
        n_checks++;
        if (mem[4] !== 32'hDEAD_BEEF) $display("FAIL wr_mem: got %h need deadbeef", mem[4]);
        else n_pass++;
    endtask

    task automatic test_read_latency();
        exp_t e;
        int   k;
        drive(1, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
        k = cyc;
        exp_q.push_back('{port: 1, data: 32'hDEAD_BEEF, cyc: k + 2});
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clock);
            if (p0_ack || p1_ack) begin
                e = exp_q.pop_front();
                n_checks++;
                if (p0_ack !== (e.port == 0) || p1_ack !== (e.port == 1) ||
                    (e.port == 1 ? p1_dat_r : p0_dat_r) !== e.data || cyc != e.cyc)
                    $display("FAIL rd_ack: got ack=%b/%b dat=%h/%h cyc=%0d need port %0d %h %0d",
                             p0_ack, p1_ack, p0_dat_r, p1_dat_r, cyc, e.port, e.data, e.cyc);
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL rd_timeout: got %0d acks missing need 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
        @(posedge clock); #1;
        idle_port(1);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   k;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        mem[16] = 32'hA5A5_0001;
        mem[17] = 32'h5A5A_0002;
        drive(0, 1'b0, 32'h0000_0040, 4'hF, 32'h0);
        drive(1, 1'b0, 32'h0000_0044, 4'hF, 32'h0);
        k = cyc;
        for (int j = 0; j < 4; j++)
            exp_q.push_back('{port: j % 2, data: (j % 2 == 0) ? 32'hA5A5_0001 : 32'h5A5A_0002,
                              cyc: k + 2 + 3 * j});
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clock);
            if (p0_ack || p1_ack) begin
                e = exp_q.pop_front();
                n_checks++;
                if (p0_ack !== (e.port == 0) || p1_ack !== (e.port == 1) ||
                    (e.port == 1 ? p1_dat_r : p0_dat_r) !== e.data || cyc != e.cyc)
                    $display("FAIL b2b_ack: got ack=%b/%b dat=%h/%h cyc=%0d need port %0d %h %0d",
                             p0_ack, p1_ack, p0_dat_r, p1_dat_r, cyc, e.port, e.data, e.cyc);
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL b2b_timeout: got %0d acks missing need 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
        @(posedge clock); #1;
        idle_port(0);
        idle_port(1);
    endtask

    task automatic test_byte_write();
        exp_t e;
        int   k;
        mem[8] = 32'h1122_3344;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                drive(0, 1'b1, 32'h0000_0020, 4'h2, 32'h0000_AB00);
                exp_q.push_back('{port: 0, data: 32'h0, cyc: cyc + 2});
            end else begin
                drive(0, 1'b0, 32'h0000_0020, 4'hF, 32'h0);
                exp_q.push_back('{port: 0, data: 32'h1122_AB44, cyc: cyc + 2});
            end
            k = cyc;
            @(posedge clock);
            @(negedge clock);
            n_checks++;
            if (sram_csb !== 1'b0 || sram_wmask !== (t == 0 ? 4'h2 : 4'h0) || sram_web !== (t == 0 ? 1'b0 : 1'b1))
                $display("FAIL byte_cmd%0d: got csb=%b web=%b wmask=%h need 0 %0d %h",
                         t, sram_csb, sram_web, sram_wmask, t, (t == 0 ? 4'h2 : 4'h0));
            else n_pass++;
            for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
                @(negedge clock);
                if (p0_ack || p1_ack) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_dat_r !== e.data || cyc != e.cyc)
                        $display("FAIL byte_ack%0d: got ack=%b/%b dat=%h cyc=%0d need 1/0 %h %0d",
                                 t, p0_ack, p1_ack, p0_dat_r, cyc, e.data, e.cyc);
                    else n_pass++;
                end
            end
            n_checks++;
            if (exp_q.size() != 0) begin
                $display("FAIL byte_timeout%0d: got %0d acks missing need 0 (req cyc %0d)", t, exp_q.size(), k);
                exp_q.delete();
            end else n_pass++;
            @(posedge clock); #1;
        end
        idle_port(0);
        n_checks++;
        if (mem[8] !== 32'h1122_AB44) $display("FAIL byte_mem: got %h need 1122ab44", mem[8]);
        else n_pass++;
    endtask

    task automatic test_abandon();
        exp_t e;
        int   k;
        mem[12] = 32'h0;
        drive(1, 1'b1, 32'h0000_0030, 4'hF, 32'hCAFE_F00D);
        k = cyc;
        exp_q.push_back('{port: 0, data: 32'hDEAD_BEEF, cyc: k + 5});
        @(posedge clock); #1;
        idle_port(1);
        drive(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
        for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
            @(negedge clock);
            if (p0_ack || p1_ack) begin
                e = exp_q.pop_front();
                n_checks++;
                if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_dat_r !== e.data || cyc != e.cyc)
                    $display("FAIL abandon_ack: got ack=%b/%b dat=%h cyc=%0d need 1/0 %h %0d",
                             p0_ack, p1_ack, p0_dat_r, cyc, e.data, e.cyc);
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL abandon_timeout: got %0d acks missing need 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
        @(posedge clock); #1;
        idle_port(0);
        n_checks++;
        if (mem[12] !== 32'hCAFE_F00D) $display("FAIL abandon_mem: got %h need cafef00d", mem[12]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        exp_t e;
        int   k;
        int   stray;
        mem[20] = 32'h0;
        drive(0, 1'b1, 32'h0000_0050, 4'hF, 32'h5555_5555);
        @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (sram_csb !== 1'b0) $display("FAIL rstmid_cmd: got csb=%b need 0", sram_csb);
        else n_pass++;
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (sram_csb !== 1'b1 || sram_web !== 1'b1)
            $display("FAIL rstmid_async: got csb=%b web=%b need 1 1", sram_csb, sram_web);
        else n_pass++;
        idle_port(0);
        @(posedge clock);
        @(posedge clock); #1;
        reset_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (p0_ack || p1_ack) stray++;
        end
        n_checks++;
        if (stray != 0) $display("FAIL rstmid_noack: got %0d acks need 0", stray);
        else n_pass++;
        n_checks++;
        if (mem[20] !== 32'h0) $display("FAIL rstmid_mem: got %h need 0", mem[20]);
        else n_pass++;
        @(posedge clock); #1;
        drive(0, 1'b0, 32'h0000_0040, 4'hF, 32'h0);
        drive(1, 1'b0, 32'h0000_0044, 4'hF, 32'h0);
        k = cyc;
        exp_q.push_back('{port: 0, data: 32'hA5A5_0001, cyc: k + 2});
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            @(negedge clock);
            if (p0_ack || p1_ack) begin
                e = exp_q.pop_front();
                n_checks++;
                if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_dat_r !== e.data || cyc != e.cyc)
                    $display("FAIL rstmid_tie: got ack=%b/%b dat=%h cyc=%0d need 1/0 %h %0d",
                             p0_ack, p1_ack, p0_dat_r, cyc, e.data, e.cyc);
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL rstmid_timeout: got %0d acks missing need 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
        @(posedge clock); #1;
        idle_port(0);
        idle_port(1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        p0_adr = '0; p0_dat_w = '0; p0_sel = '0;
        p1_adr = '0; p1_dat_w = '0; p1_sel = '0;
        idle_port(0);
        idle_port(1);
        test_reset();
        test_basic_write();
        test_read_latency();
        test_back_to_back();
        test_byte_write();
        test_abandon();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
